cordic_cos_iter: RTL and testbench

- Iterative rotation-mode CORDIC that computes cos(θ) for the fixed-point angle produced by fp_to_fixed (sign, 1 integer bit, 19 fractional bits, |θ| ≤ ~2 rad).
- Sits directly downstream of fp_to_fixed in the Monte-Carlo datapath.
- Result is an unsigned Q1.19 value in the same integer/fractional split, so the next stage consumes it unchanged.
- Handshake is start/busy/done, custom-instruction style.

---
 rtl/cordic_pkg.sv | 45 ++++
 rtl/cordic_cos_iter_if.sv | 24 ++
 rtl/cordic_atan_rom.sv | 25 ++
 rtl/cordic_cos_iter.sv | 124 ++++++++++++
 tb/tb_cordic_cos_iter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM state type for the iterative cosine CORDIC.
package cordic_pkg;

    localparam int FRAC = 19;
    localparam int DW   = FRAC + 3;
    localparam int CW   = $clog2(FRAC + 1);

    // Gain compensation 1/prod(sqrt(1+2^-2i)) for 16 micro-rotations, in Q.FRAC
    localparam logic signed [DW-1:0] K_SCALED = 22'sd318375;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;

    // round(atan(2^-i) * 2^FRAC)
    function automatic logic signed [DW-1:0] atan_entry(input int i);
        logic signed [DW-1:0] v;
        case (i)
            0:       v = 22'sd411775;
            1:       v = 22'sd243084;
            2:       v = 22'sd128439;
            3:       v = 22'sd65198;
            4:       v = 22'sd32725;
            5:       v = 22'sd16379;
            6:       v = 22'sd8191;
            7:       v = 22'sd4096;
            8:       v = 22'sd2048;
            9:       v = 22'sd1024;
            10:      v = 22'sd512;
            11:      v = 22'sd256;
            12:      v = 22'sd128;
            13:      v = 22'sd64;
            14:      v = 22'sd32;
            15:      v = 22'sd16;
            16:      v = 22'sd8;
            17:      v = 22'sd4;
            18:      v = 22'sd2;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_cos_iter_if.sv
// Start/busy/done request bundle between the angle producer and the cosine CORDIC.
interface cordic_cos_iter_if;
    import cordic_pkg::*;

    logic            start;
    logic            sign_i;
    logic            integer_i;
    logic [FRAC-1:0] fractional_i;
    logic            busy;
    logic            done;
    logic            integer_o;
    logic [FRAC-1:0] fractional_o;

    modport master (
        output start, sign_i, integer_i, fractional_i,
        input  busy, done, integer_o, fractional_o
    );

    modport slave (
        input  start, sign_i, integer_i, fractional_i,
        output busy, done, integer_o, fractional_o
    );

endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup indexed by the micro-rotation counter.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [CW-1:0]        idx,
    output logic signed [DW-1:0] angle
);

    logic signed [DW-1:0] atan_table [FRAC];

    genvar gi;
    generate
        for (gi = 0; gi < FRAC; gi++) begin : g_rom
            assign atan_table[gi] = atan_entry(gi);
        end
    endgenerate

    always_comb begin
        angle = '0;
        if (idx < CW'(FRAC)) begin
            angle = atan_table[idx];
        end
    end

endmodule

// File: rtl/cordic_cos_iter.sv
// Iterative rotation-mode CORDIC: cos of a signed Q1.19 angle, saturated to unsigned Q1.19.
module cordic_cos_iter
    import cordic_pkg::*;
#(
    parameter int ITER = 16
) (
    input  logic               clk,
    input  logic               reset,
    cordic_cos_iter_if.slave   bus
);

    state_t               state_reg, state_next;
    logic signed [DW-1:0] x_reg, x_next;
    logic signed [DW-1:0] y_reg, y_next;
    logic signed [DW-1:0] z_reg, z_next;
    logic [CW-1:0]        count_reg, count_next;
    logic                 done_reg, done_next;
    logic                 int_reg, int_next;
    logic [FRAC-1:0]      frac_reg, frac_next;

    logic signed [DW-1:0] atan_val;
    logic signed [DW-1:0] x_sh, y_sh, z_load;
    logic                 load;

    cordic_atan_rom u_rom (
        .idx   (count_reg),
        .angle (atan_val)
    );

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        z_next     = z_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        int_next   = int_reg;
        frac_next  = frac_reg;
        load       = 1'b0;

        x_sh   = x_reg >>> count_reg;
        y_sh   = y_reg >>> count_reg;
        z_load = {{(DW-FRAC-1){1'b0}}, bus.integer_i, bus.fractional_i};
        if (bus.sign_i) begin
            z_load = -z_load;
        end

        case (state_reg)
            IDLE: begin
                load = bus.start;
            end
            ROTATE: begin
                if (!z_reg[DW-1]) begin
                    x_next = x_reg - y_sh;
                    y_next = y_reg + x_sh;
                    z_next = z_reg - atan_val;
                end else begin
                    x_next = x_reg + y_sh;
                    y_next = y_reg - x_sh;
                    z_next = z_reg + atan_val;
                end
                count_next = count_reg + 1'b1;
                if (count_reg == CW'(ITER - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Result is registered here; a start in this cycle reloads at the same edge
                done_next = 1'b1;
                if (x_reg[DW-1]) begin
                    int_next  = 1'b0;
                    frac_next = '0;
                end else if (|x_reg[DW-2:FRAC]) begin
                    int_next  = 1'b1;
                    frac_next = '0;
                end else begin
                    int_next  = 1'b0;
                    frac_next = x_reg[FRAC-1:0];
                end
                load = bus.start;
                if (!bus.start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            x_next     = K_SCALED;
            y_next     = '0;
            z_next     = z_load;
            count_next = '0;
            state_next = ROTATE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
            int_reg   <= 1'b0;
            frac_reg  <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
            count_reg <= count_next;
            done_reg  <= done_next;
            int_reg   <= int_next;
            frac_reg  <= frac_next;
        end
    end

    assign bus.busy         = (state_reg != IDLE);
    assign bus.done         = done_reg;
    assign bus.integer_o    = int_reg;
    assign bus.fractional_o = frac_reg;

endmodule

// File: tb/tb_cordic_cos_iter.sv
// Self-checking bench for cordic_cos_iter: directed/random vectors against a $cos model plus handshake corner cases.
module tb_cordic_cos_iter;
    import cordic_pkg::*;

    localparam int LAT = 17;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cordic_cos_iter_if bus ();

    cordic_cos_iter #(.ITER(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit s;
        bit i;
        int f;
        int exp;
        int tol;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int got, input int exp, input int tol);
        checks++;
        if ((got - exp > tol) || (exp - got > tol)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, got, exp, tol);
        end
    endtask

    function automatic int result_val();
        return int'({bus.integer_o, bus.fractional_o});
    endfunction

    // Reference: real cosine of the angle, scaled and clamped to [0, 1.0]
    function automatic int ref_cos(input bit s, input bit i, input int f);
        real th;
        real c;
        th = (real'(i) * 524288.0 + real'(f)) / 524288.0;
        if (s) th = -th;
        c = $cos(th) * 524288.0;
        if (c <= 0.0) return 0;
        if (c >= 524288.0) return 524288;
        return $rtoi(c + 0.5);
    endfunction

    task automatic set_angle(input bit s, input bit i, input int f);
        bus.sign_i       = s;
        bus.integer_i    = i;
        bus.fractional_i = f[FRAC-1:0];
    endtask

    task automatic launch(input bit s, input bit i, input int f);
        @(negedge clk);
        set_angle(s, i, f);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after the load edge until done is seen; bounded
    task automatic wait_done(output int lat, output int busy_bad);
        lat = 0;
        busy_bad = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) break;
            if (!bus.busy) busy_bad++;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat, bb;
        launch(v.s, v.i, v.f);
        wait_done(lat, bb);
        check({name, " latency"}, lat, LAT, 0);
        check({name, " busy_drop"}, bb, 0, 0);
        check({name, " busy_at_done"}, int'(bus.busy), 0, 0);
        check({name, " result"}, result_val(), v.exp, v.tol);
        $display("op %s s=%0d int=%0d frac=%0d lat=%0d result=%0d expected=%0d", name, v.s, v.i, v.f, lat, result_val(), v.exp);
        @(negedge clk);
        check({name, " done_pulse"}, int'(bus.done), 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bb, pulses, busy_cnt;
        bit s;
        logic [19:0] mag;
        vec_t v;

        bus.start = 1'b0;
        set_angle(1'b0, 1'b0, 0);

        vecs.push_back('{0, 0, 0,       524288, 4});
        vecs.push_back('{0, 1, 0,       283276, 4});
        vecs.push_back('{1, 0, 'h40000, 460105, 4});
        vecs.push_back('{0, 0, 'h40000, 460105, 4});
        vecs.push_back('{0, 0, 'h20000, 507987, 4});
        vecs.push_back('{0, 0, 'h60000, 383613, 4});
        for (int k = 0; k < 16; k++) begin
            s   = 1'($urandom_range(0, 1));
            mag = 20'($urandom_range(0, 891289));
            v.s = s;
            v.i = mag[19];
            v.f = int'(mag[18:0]);
            v.exp = ref_cos(v.s, v.i, v.f);
            v.tol = 32;
            vecs.push_back(v);
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", int'(bus.busy), 0, 0);
        check("reset done", int'(bus.done), 0, 0);
        check("reset result", result_val(), 0, 0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            run_vec($sformatf("vec%0d", k), vecs[k]);
        end

        // Start re-asserted mid-operation with another angle must be ignored
        launch(0, 1, 0);
        lat = 0;
        bb = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 6) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (lat == 5) begin
                set_angle(0, 0, 'h20000);
                bus.start = 1'b1;
            end
            if (bus.done) break;
            if (!bus.busy) bb++;
        end
        check("midstart latency", lat, LAT, 0);
        check("midstart busy_drop", bb, 0, 0);
        check("midstart result", result_val(), 283276, 4);
        $display("op midstart lat=%0d result=%0d expected=283276", lat, result_val());
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("midstart extra_done", pulses, 0, 0);

        // Reset mid-operation aborts without a done pulse
        launch(0, 0, 'h40000);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort busy", int'(bus.busy), 0, 0);
        check("abort done", int'(bus.done), 0, 0);
        check("abort result", result_val(), 0, 0);
        reset = 1'b0;
        pulses = 0;
        busy_cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) pulses++;
            if (bus.busy) busy_cnt++;
        end
        check("abort done_after", pulses, 0, 0);
        check("abort busy_after", busy_cnt, 0, 0);
        $display("op abort pulses=%0d busy_cycles=%0d", pulses, busy_cnt);
        v = '{0, 0, 'h40000, 460105, 4};
        run_vec("after_abort", v);

        // Start held high, alternating 0.25 / 0.75, back-to-back
        @(negedge clk);
        set_angle(0, 0, 'h20000);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        set_angle(0, 0, 'h60000);
        for (int k = 0; k < 5; k++) begin
            wait_done(lat, bb);
            check($sformatf("b2b%0d latency", k), lat, LAT, 0);
            check($sformatf("b2b%0d busy_drop", k), bb, 0, 0);
            check($sformatf("b2b%0d result", k), result_val(), (k % 2 == 0) ? 507987 : 383613, 4);
            $display("op b2b%0d lat=%0d result=%0d expected=%0d", k, lat, result_val(), (k % 2 == 0) ? 507987 : 383613);
            if (k < 4) begin
                check($sformatf("b2b%0d busy_reload", k), int'(bus.busy), 1, 0);
            end
            if (k < 3) begin
                set_angle(0, 0, (k % 2 == 0) ? 'h20000 : 'h60000);
            end else begin
                bus.start = 1'b0;
            end
        end

        // Outside convergence: result undefined but timing must hold
        launch(0, 1, 'h7FFFF);
        wait_done(lat, bb);
        check("outrange latency", lat, LAT, 0);
        check("outrange busy_drop", bb, 0, 0);
        $display("op outrange lat=%0d result=%0d", lat, result_val());
        @(negedge clk);
        check("outrange done_pulse", int'(bus.done), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
